// File: rtl/vga_pkg.sv
// -----------------------------------------------------------------------------
// vga_pkg
// Types and constants shared by the VGA raster timing generator.
//   vga_timing_t        : segment lengths of one raster axis, in pixels or lines
//   VGA_640X480_H/_V    : 640x480@60 segment lengths
//   VGA_640X480_CLK_DIV : system clocks per pixel for a 50 MHz board clock
//   total()             : full period of one axis (sum of its four segments)
// -----------------------------------------------------------------------------
package vga_pkg;

  // One axis of a video mode. Segment order along the axis is
  // display, front porch, sync, back porch.
  typedef struct packed {
    int display;
    int front;
    int sync;
    int back;
  } vga_timing_t;

  localparam vga_timing_t VGA_640X480_H = '{display: 640, front: 16, sync: 96, back: 48};
  localparam vga_timing_t VGA_640X480_V = '{display: 480, front: 10, sync: 2,  back: 33};
  localparam int          VGA_640X480_CLK_DIV = 2;

  // Number of pixels (or lines) in one full period of an axis.
  function automatic int total(input vga_timing_t t);
    return t.display + t.front + t.sync + t.back;
  endfunction

endpackage

// File: rtl/vga_timing_gen_if.sv
// -----------------------------------------------------------------------------
// vga_timing_gen_if
// Bundle between the raster timing generator and its consumers
// (pixel/framebuffer logic and the DAC control pins).
//   en          : run enable, driven by the consumer side
//   h_sync      : horizontal sync (polarity set by the generator)
//   v_sync      : vertical sync (polarity set by the generator)
//   blank_n     : 1 during active video
//   sync_n      : constant 1 (no sync-on-green)
//   active      : same as blank_n, for pixel logic
//   posx, posy  : current pixel coordinate, 0 outside active video
//   pix_tick    : one clk high per raster advance
//   line_start  : one clk high on entering column 0
//   frame_start : one clk high on entering (0,0)
// Modports: master = generator side, slave = consumer side.
// -----------------------------------------------------------------------------
interface vga_timing_gen_if #(
  parameter int CW = 10
) ();

  logic          en;
  logic          h_sync;
  logic          v_sync;
  logic          blank_n;
  logic          sync_n;
  logic          active;
  logic [CW-1:0] posx;
  logic [CW-1:0] posy;
  logic          pix_tick;
  logic          line_start;
  logic          frame_start;

  modport master (
    input  en,
    output h_sync, v_sync, blank_n, sync_n, active,
    output posx, posy, pix_tick, line_start, frame_start
  );

  modport slave (
    output en,
    input  h_sync, v_sync, blank_n, sync_n, active,
    input  posx, posy, pix_tick, line_start, frame_start
  );

endinterface

// File: rtl/vga_axis_counter.sv
// -----------------------------------------------------------------------------
// vga_axis_counter
// Position counter for one raster axis (horizontal or vertical).
// Parameters:
//   CW  : counter width
//   SEG : segment lengths of the axis (display, front, sync, back)
//   POL : asserted level of the sync output
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   i_advance  : step the counter by one this cycle
//   o_count    : counter value after this cycle's step (value about to be
//                registered), so the parent can register outputs with no
//                extra latency
//   o_in_disp  : o_count lies in the display segment
//   o_sync     : registered sync level describing the registered count
//   o_wrap     : this step takes the counter from TOTAL-1 back to 0
// Reset parks the counter on TOTAL-1 so the first step lands on 0.
// -----------------------------------------------------------------------------
module vga_axis_counter
  import vga_pkg::*;
#(
  parameter int          CW  = 10,
  parameter vga_timing_t SEG = VGA_640X480_H,
  parameter bit          POL = 1'b0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_advance,
  output logic [CW-1:0] o_count,
  output logic          o_in_disp,
  output logic          o_sync,
  output logic          o_wrap
);

  localparam int TOTAL = total(SEG);

  // Boundaries carry one extra bit so a segment ending exactly at 2^CW
  // still compares correctly.
  localparam logic [CW:0] LAST     = (CW+1)'(TOTAL - 1);
  localparam logic [CW:0] DISP_END = (CW+1)'(SEG.display);
  localparam logic [CW:0] SYNC_BEG = (CW+1)'(SEG.display + SEG.front);
  localparam logic [CW:0] SYNC_END = (CW+1)'(SEG.display + SEG.front + SEG.sync);

  logic [CW-1:0] r_count;
  logic          r_sync;
  logic          w_at_last;
  logic [CW:0]   w_count_ext;
  logic          w_sync_nxt;

  assign w_at_last = ({1'b0, r_count} == LAST);
  assign o_wrap    = i_advance && w_at_last;

  always_comb begin
    o_count = r_count;
    if (i_advance) begin
      o_count = w_at_last ? '0 : r_count + 1'b1;
    end
  end

  assign w_count_ext = {1'b0, o_count};
  assign o_in_disp   = (w_count_ext < DISP_END);
  assign w_sync_nxt  = (w_count_ext >= SYNC_BEG) && (w_count_ext < SYNC_END);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= LAST[CW-1:0];
      r_sync  <= !POL;
    end else if (i_advance) begin
      r_count <= o_count;
      r_sync  <= w_sync_nxt ? POL : !POL;
    end
  end

  assign o_sync = r_sync;

endmodule

// File: rtl/vga_timing_gen.sv
// -----------------------------------------------------------------------------
// vga_timing_gen
// Parametrised VGA raster timing generator. Produces sync, blanking,
// active-video flag, pixel coordinates and line/frame strobes for any mode
// given by its porch/sync/display lengths.
// Ports:
//   clk   : system clock
//   rst_n : asynchronous active-low reset
//   bus   : vga_timing_gen_if.master (en in; syncs, blanking, posx/posy,
//           pix_tick, line_start, frame_start out)
// Configuration macro VGA_TIMING_CLKDIV_EN:
//   defined   - a modulo-CLK_DIV divider produces the pixel tick, so the
//               raster advances once every CLK_DIV system clocks
//   undefined - clk is the pixel clock, the raster advances every enabled
//               clk and CLK_DIV is ignored
// All outputs are registered and are loaded from the counters' next values,
// so they describe the counter position with no added latency.
// -----------------------------------------------------------------------------
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int CW        = 10,
  parameter int H_DISPLAY = VGA_640X480_H.display,
  parameter int H_FRONT   = VGA_640X480_H.front,
  parameter int H_SYNC    = VGA_640X480_H.sync,
  parameter int H_BACK    = VGA_640X480_H.back,
  parameter int V_DISPLAY = VGA_640X480_V.display,
  parameter int V_FRONT   = VGA_640X480_V.front,
  parameter int V_SYNC    = VGA_640X480_V.sync,
  parameter int V_BACK    = VGA_640X480_V.back,
  parameter bit H_POL     = 1'b0,
  parameter bit V_POL     = 1'b0,
  parameter int CLK_DIV   = VGA_640X480_CLK_DIV
) (
  input logic               clk,
  input logic               rst_n,
  vga_timing_gen_if.master  bus
);

  localparam vga_timing_t H_TIMING = '{display: H_DISPLAY, front: H_FRONT,
                                       sync: H_SYNC, back: H_BACK};
  localparam vga_timing_t V_TIMING = '{display: V_DISPLAY, front: V_FRONT,
                                       sync: V_SYNC, back: V_BACK};

  // ---------------------------------------------------------------------------
  // Elaboration-time parameter checks
  // ---------------------------------------------------------------------------
  if (total(H_TIMING) > (1 << CW)) begin : g_h_total_too_big
    $error("vga_timing_gen: H_TOTAL does not fit in CW bits");
  end
  if (total(V_TIMING) > (1 << CW)) begin : g_v_total_too_big
    $error("vga_timing_gen: V_TOTAL does not fit in CW bits");
  end
  if (CLK_DIV < 1) begin : g_clk_div_too_small
    $error("vga_timing_gen: CLK_DIV must be at least 1");
  end

  // ---------------------------------------------------------------------------
  // Pixel tick
  // ---------------------------------------------------------------------------
  logic w_tick;

`ifdef VGA_TIMING_CLKDIV_EN
  localparam int            DW       = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

  logic [DW-1:0] r_div;

  // The divider only counts enabled clocks, so its phase survives pauses
  // and the first tick after enabling lands CLK_DIV clocks later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_div <= '0;
    end else if (bus.en) begin
      r_div <= (r_div == DIV_LAST) ? '0 : r_div + 1'b1;
    end
  end

  assign w_tick = bus.en && (r_div == DIV_LAST);
`else
  assign w_tick = bus.en;
`endif

  // ---------------------------------------------------------------------------
  // Axis counters: the vertical axis steps on the horizontal wrap
  // ---------------------------------------------------------------------------
  logic [CW-1:0] w_h_count;
  logic [CW-1:0] w_v_count;
  logic          w_h_disp;
  logic          w_v_disp;
  logic          w_h_sync;
  logic          w_v_sync;
  logic          w_h_wrap;
  logic          w_v_wrap;

  vga_axis_counter #(
    .CW  (CW),
    .SEG (H_TIMING),
    .POL (H_POL)
  ) u_h_axis (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_advance (w_tick),
    .o_count   (w_h_count),
    .o_in_disp (w_h_disp),
    .o_sync    (w_h_sync),
    .o_wrap    (w_h_wrap)
  );

  vga_axis_counter #(
    .CW  (CW),
    .SEG (V_TIMING),
    .POL (V_POL)
  ) u_v_axis (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_advance (w_h_wrap),
    .o_count   (w_v_count),
    .o_in_disp (w_v_disp),
    .o_sync    (w_v_sync),
    .o_wrap    (w_v_wrap)
  );

  // ---------------------------------------------------------------------------
  // Coordinates, active flag and strobes
  // ---------------------------------------------------------------------------
  logic          w_active_nxt;
  logic          r_active;
  logic [CW-1:0] r_posx;
  logic [CW-1:0] r_posy;
  logic          r_pix_tick;
  logic          r_line_start;
  logic          r_frame_start;

  assign w_active_nxt = w_h_disp && w_v_disp;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_active      <= 1'b0;
      r_posx        <= '0;
      r_posy        <= '0;
      r_pix_tick    <= 1'b0;
      r_line_start  <= 1'b0;
      r_frame_start <= 1'b0;
    end else begin
      // Strobes are refreshed every clock, so they are high for exactly the
      // first cycle that shows the new position.
      r_pix_tick    <= w_tick;
      r_line_start  <= w_h_wrap;
      // The vertical wrap can only happen on a horizontal wrap, i.e. (0,0).
      r_frame_start <= w_v_wrap;
      if (w_tick) begin
        r_active <= w_active_nxt;
        r_posx   <= w_active_nxt ? w_h_count : '0;
        r_posy   <= w_active_nxt ? w_v_count : '0;
      end
    end
  end

  assign bus.h_sync      = w_h_sync;
  assign bus.v_sync      = w_v_sync;
  assign bus.blank_n     = r_active;
  assign bus.active      = r_active;
  assign bus.sync_n      = 1'b1;
  assign bus.posx        = r_posx;
  assign bus.posy        = r_posy;
  assign bus.pix_tick    = r_pix_tick;
  assign bus.line_start  = r_line_start;
  assign bus.frame_start = r_frame_start;

endmodule

// File: tb/tb_vga_timing_gen.sv
// -----------------------------------------------------------------------------
// tb_vga_timing_gen
// Self-checking bench for vga_timing_gen using a small video mode so whole
// frames fit in a short run. Every clock the DUT outputs are compared with a
// reference computed arithmetically from the number of enabled clocks since
// reset. Targeted checks cover reset, frame period and per-frame counts,
// a 37-clock pause and an asynchronous reset in mid-frame.
// -----------------------------------------------------------------------------
module tb_vga_timing_gen;

  localparam int CW = 6;
  localparam int HD = 16, HF = 3, HS = 4, HB = 5;
  localparam int VD = 10, VF = 2, VS = 2, VB = 3;
  localparam bit HP = 1'b0;
  localparam bit VP = 1'b1;
  localparam int CD = 3;
`ifdef VGA_TIMING_CLKDIV_EN
  localparam int DIV = CD;
`else
  localparam int DIV = 1;
`endif
  localparam int HT = HD + HF + HS + HB;   // 28
  localparam int VT = VD + VF + VS + VB;   // 17
  localparam int F  = HT * VT;             // pixels per frame

  // {h_sync, v_sync, blank_n, sync_n, active, posx, posy, pix_tick, line_start, frame_start}
  localparam logic [63:0] RST_VEC    = 64'({!HP, !VP, 1'b0, 1'b1, 1'b0,
                                            {CW{1'b0}}, {CW{1'b0}}, 3'b000});
  localparam logic [63:0] LEVEL_MASK = ~64'h7;

  logic clk = 1'b0;
  logic rst_n;

  vga_timing_gen_if #(.CW(CW)) vif ();

  vga_timing_gen #(
    .CW(CW), .H_DISPLAY(HD), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_DISPLAY(VD), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
    .H_POL(HP), .V_POL(VP), .CLK_DIV(CD)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (vif)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: enabled clocks since reset and whether the last edge
  // was enabled. Everything else follows by arithmetic.
  // ---------------------------------------------------------------------------
  int m_n;
  bit m_last_en;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_n       <= 0;
      m_last_en <= 1'b0;
    end else begin
      m_last_en <= vif.en;
      if (vif.en) m_n <= m_n + 1;
    end
  end

  function automatic logic [63:0] model_vec();
    int ticks = m_n / DIV;
    int p     = (ticks + F - 1) % F;   // reset parks on the last pixel
    int x     = p % HT;
    int y     = p / HT;
    bit tk    = m_last_en && (m_n % DIV == 0);
    bit act   = (x < HD) && (y < VD);
    bit hs    = (x >= HD + HF && x < HD + HF + HS) ? HP : !HP;
    bit vs    = (y >= VD + VF && y < VD + VF + VS) ? VP : !VP;
    logic [CW-1:0] px = act ? CW'(x) : '0;
    logic [CW-1:0] py = act ? CW'(y) : '0;
    return 64'({hs, vs, act, 1'b1, act, px, py, tk, tk && (x == 0), tk && (p == 0)});
  endfunction

  function automatic logic [63:0] dut_vec();
    return 64'({vif.h_sync, vif.v_sync, vif.blank_n, vif.sync_n, vif.active,
                vif.posx, vif.posy, vif.pix_tick, vif.line_start, vif.frame_start});
  endfunction

  // One clock, then the full-output comparison on the falling edge.
  task automatic cycle();
    @(negedge clk);
    if (n_bad < 40) chk("cyc", dut_vec(), model_vec());
  endtask

  initial begin
    int k, nls, maxy, nact, nhs, nvs, nstr;
    bit found;
    logic [63:0] snap;

    vif.en = 1'b0;
    rst_n  = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_state", dut_vec(), RST_VEC);

    // First frame from reset with en held high.
    rst_n  = 1'b1;
    vif.en = 1'b1;
    k = 0;
    do begin cycle(); k++; end while (vif.frame_start !== 1'b1 && k < 4 * DIV);
    chk("first_fs_latency", k, DIV);
    chk("first_fs_pos", {vif.posx, vif.posy, vif.active}, {{CW{1'b0}}, {CW{1'b0}}, 1'b1});

    k = 0; nls = 0; maxy = 0; nact = 0; nhs = 0; nvs = 0;
    do begin
      cycle(); k++;
      if (vif.line_start) nls++;
      if (int'(vif.posy) > maxy) maxy = int'(vif.posy);
      if (vif.pix_tick && vif.active) nact++;
      if (vif.pix_tick && vif.h_sync == HP) nhs++;
      if (vif.pix_tick && vif.v_sync == VP) nvs++;
    end while (vif.frame_start !== 1'b1 && k < 2 * F * DIV);
    chk("frame_period", k, F * DIV);
    chk("lines_per_frame", nls, VT);
    chk("posy_max", maxy, VD - 1);
    chk("active_ticks", nact, HD * VD);
    chk("hsync_ticks", nhs, HS * VT);
    chk("vsync_ticks", nvs, VS * HT);

    // Random enable over several frames.
    repeat (3 * F * DIV) begin
      vif.en = ($urandom_range(0, 99) < 85);
      cycle();
    end

    // Pause for 37 clocks just after the raster entered column 5.
    vif.en = 1'b1;
    found  = 1'b0;
    for (int i = 0; i < 2 * F * DIV && !found; i++) begin
      cycle();
      if (vif.posx == CW'(5) && vif.pix_tick) found = 1'b1;
    end
    chk("find_x5", found, 1'b1);
    snap   = dut_vec() & LEVEL_MASK;
    vif.en = 1'b0;
    nstr   = 0;
    repeat (37) begin
      cycle();
      if (vif.pix_tick || vif.line_start || vif.frame_start) nstr++;
    end
    chk("pause_levels", dut_vec() & LEVEL_MASK, snap);
    chk("pause_strobes", nstr, 0);
    vif.en = 1'b1;
    k = 0;
    do begin cycle(); k++; end while (vif.pix_tick !== 1'b1 && k < DIV + 2);
    chk("resume_latency", k, DIV);
    chk("resume_posx", vif.posx, 6);

    // Asynchronous reset in the middle of the frame.
    found = 1'b0;
    for (int i = 0; i < 2 * F * DIV && !found; i++) begin
      cycle();
      if (vif.posx == CW'(HD / 2) && vif.posy == CW'(VD / 2)) found = 1'b1;
    end
    chk("find_mid", found, 1'b1);
    #2 rst_n = 1'b0;
    #1 chk("async_reset", dut_vec(), RST_VEC);
    vif.en = 1'b0;
    repeat (3) cycle();
    rst_n  = 1'b1;
    vif.en = 1'b1;
    k = 0;
    do begin cycle(); k++; end while (vif.frame_start !== 1'b1 && k < 4 * DIV);
    chk("rst_fs_latency", k, DIV);
    chk("rst_fs_pos", {vif.posx, vif.posy, vif.active, vif.line_start},
        {{CW{1'b0}}, {CW{1'b0}}, 1'b1, 1'b1});
    repeat (2 * HT * DIV) cycle();

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Parametrised VGA raster timing generator for the display pipeline. Produces horizontal/vertical sync, blanking, active-video flag, pixel coordinates and line/frame strobes from one system clock, for any mode described by its porch/sync/display parameters. It sits between the board clock and the pixel/framebuffer logic that consumes `posx`/`posy`, and drives the DAC control pins directly.

## Interface
- `CW`, 10: width of the horizontal/vertical counters and of `posx`/`posy`.
- `H_DISPLAY`, 640: visible pixels per line.
- `H_FRONT`, 16: horizontal front porch, in pixels.
- `H_SYNC`, 96: horizontal sync width, in pixels.
- `H_BACK`, 48: horizontal back porch, in pixels.
- `V_DISPLAY`, 480: visible lines per frame.
- `V_FRONT`, 10: vertical front porch, in lines.
- `V_SYNC`, 2: vertical sync width, in lines.
- `V_BACK`, 33: vertical back porch, in lines.
- `H_POL`, 0: asserted level of `h_sync` (0 = active-low).
- `V_POL`, 0: asserted level of `v_sync` (0 = active-low).
- `CLK_DIV`, 2: system clocks per pixel. Range ≥1; used only with `VGA_TIMING_CLKDIV_EN`.
- `clk  in  1`: system clock.
- `rst_n  in  1`: asynchronous, active-low reset.
- `en  in  1`: run enable. Low freezes the raster.
- `h_sync  out  1`: horizontal sync, polarity set by `H_POL`.
- `v_sync  out  1`: vertical sync, polarity set by `V_POL`.
- `blank_n  out  1`: 1 during active video, 0 otherwise.
- `sync_n  out  1`: constant 1 (no sync-on-green).
- `active  out  1`: same as `blank_n`, for pixel logic.
- `posx  out  CW`: current column, 0..H_DISPLAY-1 when active, else 0.
- `posy  out  CW`: current line, 0..V_DISPLAY-1 when active, else 0.
- `pix_tick  out  1`: high in each clk cycle in which the raster advances.
- `line_start  out  1`: one-clk pulse on entering column 0.
- `frame_start  out  1`: one-clk pulse on entering (0,0).

## Operation
- H_TOTAL = H_DISPLAY+H_FRONT+H_SYNC+H_BACK; V_TOTAL likewise.
- Elaboration fails if H_TOTAL or V_TOTAL exceeds 2^CW.
- Line order: display [0, H_DISPLAY), front porch, sync [H_DISPLAY+H_FRONT, +H_SYNC), back porch. Vertical segments use the same order.
- `hcount` advances on each tick with `en`=1 and wraps H_TOTAL-1→0. On that wrap, `vcount` advances and wraps V_TOTAL-1→0.
- Reset state: `hcount`=H_TOTAL-1, `vcount`=V_TOTAL-1. The first enabled tick enters (0,0).
- Outputs are registered and describe the current counter values (computed from next-state, no extra latency).
- Reset values of outputs: `h_sync`=!H_POL, `v_sync`=!V_POL, `blank_n`=0, `active`=0, `posx`=`posy`=0, `pix_tick`=0, `line_start`=0, `frame_start`=0, `sync_n`=1.
- `active` = (hcount<H_DISPLAY) && (vcount<V_DISPLAY).
- `h_sync` is asserted across the whole horizontal sync segment regardless of line. `v_sync` is asserted across whole vertical-sync lines.
- `en` low: counters and all level outputs hold; `pix_tick`, `line_start` and `frame_start` stay 0. The divider also holds.
- `rst_n` asserted mid-frame: immediate return to the reset state; no partial pulses.

## Timing
- `pix_tick` is high once every CLK_DIV clk cycles while `en`=1.
- Level outputs change in the cycle after a tick and then hold for CLK_DIV clks.
- `line_start` and `frame_start` are high for exactly one clk: the first cycle showing column 0 (respectively (0,0)).
- Frame period = H_TOTAL·V_TOTAL·CLK_DIV clks (defaults: 800·525·2 = 840 000).
- `en` rising: the first tick occurs CLK_DIV clks later; the divider phase is kept across pauses.

## Configuration
- `VGA_TIMING_CLKDIV_EN` defined: an internal modulo-CLK_DIV divider generates the tick. This suits a 50 MHz board clock driving 25 MHz pixels.
- Not defined: the tick is every clk (clk is the pixel clock), `pix_tick`=`en` registered, and CLK_DIV is ignored.
- Port list is identical in both builds.

## Structure
- `vga_pkg` holds:
  - the `vga_timing_t` struct (display/front/sync/back per axis);
  - the 640×480@60 default constants;
  - a `total()` function.
- Sub-module `vga_axis_counter`, instantiated twice (h and v):
  - parameters: segment lengths, polarity, CW;
  - inputs: `clk`, `rst_n`, advance;
  - outputs: count, in-display, in-sync, wrap.
- The top level owns the divider, coordinate masking and pulse generation.

## Test plan
- Reset then `en`=1, defaults with CLKDIV: the first `frame_start` comes 2 clks after `en`. The next `frame_start` follows exactly 840 000 clks later.
- One line: `blank_n` high 640 ticks, low 160. `h_sync` low for ticks 656..751 of the line. `posx` counts 0..639 and then reads 0.
- One frame: `v_sync` low on lines 490–491 only. `posy` reaches 479. Exactly 525 `line_start` pulses per `frame_start`.
- Drop `en` for 37 clks mid-line: all outputs frozen, no strobes; resumes at the same (posx,posy) with the divider phase intact.
- Assert `rst_n`=0 at (320,240): outputs return to their reset values asynchronously. Release: the first enabled tick gives `frame_start` at (0,0).
- Parameter set 800×600 (40/128/88, 1/4/23), H_POL=V_POL=1, CLK_DIV=1, CW=11: H_TOTAL=1056, V_TOTAL=628, syncs active-high.
